// File: rtl/io_load_sequencer.sv
// IO load path sequencer: gathers compressed sections for each row, runs the
// decompressor, then hands the row to the DMA at an auto-incrementing RAM base.
module io_load_sequencer #(
  parameter int                     sectionSize = 16,
  parameter int                     rowSize     = 512,
  parameter int                     CNN_ROWS    = 64,
  parameter int                     IMG_ROWS    = 32,
  parameter logic [sectionSize-1:0] CNN_BASE    = 16'h0000,
  parameter logic [sectionSize-1:0] IMG_BASE    = 16'h4000,
  parameter int                     TIMEOUT     = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   cnn_img,
  input  logic                   interrupt,
  input  logic                   in_valid,
  input  logic                   decompressor_done,
  input  logic                   dma_done,
  output logic                   io_interface_en,
  output logic                   decompressor_en,
  output logic                   dma_enable,
  output logic [sectionSize-1:0] dma_base,
  output logic [7:0]             row_count,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic                   error
);

  localparam int ROW_WORDS = rowSize / sectionSize;
  localparam int SEC_W     = $clog2(ROW_WORDS);
  localparam int WDOG_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DECOMP,
    DMA,
    NEXT,
    FINISH
  } state_e;

  state_e                 state_q, state_d;
  logic [SEC_W-1:0]       secCnt_q, secCnt_d;
  logic [WDOG_W-1:0]      wdog_q, wdog_d;
  logic [7:0]             rowsTarget_q, rowsTarget_d;
  logic [7:0]             rowCount_q, rowCount_d;
  logic [sectionSize-1:0] dmaBase_q, dmaBase_d;
  logic                   aborted_q, aborted_d;
  logic                   error_q, error_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      secCnt_q     <= '0;
      wdog_q       <= '0;
      rowsTarget_q <= '0;
      rowCount_q   <= '0;
      dmaBase_q    <= '0;
      aborted_q    <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      secCnt_q     <= secCnt_d;
      wdog_q       <= wdog_d;
      rowsTarget_q <= rowsTarget_d;
      rowCount_q   <= rowCount_d;
      dmaBase_q    <= dmaBase_d;
      aborted_q    <= aborted_d;
      error_q      <= error_d;
    end
  end

  // Interrupt pre-empts everything outside IDLE, including a same-cycle done
  // or accepted section, so those strobes live inside the non-abort branch.
  always_comb begin
    state_d         = state_q;
    secCnt_d        = secCnt_q;
    wdog_d          = wdog_q;
    rowsTarget_d    = rowsTarget_q;
    rowCount_d      = rowCount_q;
    dmaBase_d       = dmaBase_q;
    aborted_d       = 1'b0;
    error_d         = error_q;
    io_interface_en = 1'b0;
    done            = 1'b0;

    if (state_q != IDLE && interrupt) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            rowsTarget_d = cnn_img ? 8'(CNN_ROWS) : 8'(IMG_ROWS);
            dmaBase_d    = cnn_img ? CNN_BASE : IMG_BASE;
            rowCount_d   = '0;
            secCnt_d     = '0;
            error_d      = 1'b0;
            state_d      = COLLECT;
          end
        end
        COLLECT: begin
          io_interface_en = in_valid;
          if (in_valid) begin
            secCnt_d = secCnt_q + 1'b1;
            if (secCnt_q == SEC_W'(ROW_WORDS - 1)) begin
              wdog_d  = '0;
              state_d = DECOMP;
            end
          end
        end
        DECOMP: begin
          if (decompressor_done) begin
            wdog_d  = '0;
            state_d = DMA;
          end else if (wdog_q == WDOG_W'(TIMEOUT)) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
        DMA: begin
          if (dma_done) begin
            wdog_d  = '0;
            state_d = NEXT;
          end else if (wdog_q == WDOG_W'(TIMEOUT)) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
        NEXT: begin
          rowCount_d = rowCount_q + 8'd1;
          dmaBase_d  = dmaBase_q + sectionSize'(ROW_WORDS);
          state_d    = (rowCount_d == rowsTarget_q) ? FINISH : COLLECT;
        end
        FINISH: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign decompressor_en = (state_q == DECOMP);
  assign dma_enable      = (state_q == DMA);
  assign busy            = (state_q != IDLE);
  assign dma_base        = dmaBase_q;
  assign row_count       = rowCount_q;
  assign aborted         = aborted_q;
  assign error           = error_q;

endmodule
